// File: rtl/rns_reverse_conv_32_17_13_11.sv
// Reverse converter for the RNS moduli set {32,17,13,11} using iterative mixed-radix conversion.
// One MRC digit is produced per state; the result is held in OUT until the downstream accepts it.
module rns_reverse_conv_32_17_13_11 #(
    parameter int unsigned X_W         = 17,
    parameter int unsigned CHECK_RANGE = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [4:0]     r32,
    input  logic [4:0]     r17,
    input  logic [3:0]     r13,
    input  logic [3:0]     r11,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [X_W-1:0] out_x,
    output logic           err
);

    typedef enum logic [2:0] {StIdle, StA2, StA3, StA4, StSum, StOut} state_e;

    state_e         state_q;
    logic [4:0]     r17_q;
    logic [3:0]     r13_q;
    logic [3:0]     r11_q;
    logic [4:0]     a1_q;
    logic [4:0]     a2_q;
    logic [3:0]     a3_q;
    logic [3:0]     a4_q;
    logic           err_flag_q;
    logic           out_valid_q;
    logic [X_W-1:0] out_x_q;
    logic           err_q;

    logic [4:0]     a2_d;
    logic [3:0]     a3_d;
    logic [3:0]     a4_d;
    logic [X_W-1:0] x_d;
    int unsigned    t_a3;
    int unsigned    t1_a4;
    int unsigned    t2_a4;
    logic [31:0]    sum_w;

    // Subtrahend is reduced mod m first; a negative difference wraps by adding m once.
    function automatic int unsigned msub(input int unsigned a, input int unsigned b,
                                         input int unsigned m);
        int unsigned br;
        br = b % m;
        return (a >= br) ? (a - br) : (a + m - br);
    endfunction

    function automatic int unsigned mmul(input int unsigned a, input int unsigned k,
                                         input int unsigned m);
        return (a * k) % m;
    endfunction

    always_comb begin
        a2_d  = 5'(mmul(msub(32'(r17_q), 32'(a1_q), 17), 8, 17));
        t_a3  = mmul(msub(32'(r13_q), 32'(a1_q), 13), 11, 13);
        a3_d  = 4'(mmul(msub(t_a3, 32'(a2_q), 13), 10, 13));
        t1_a4 = mmul(msub(32'(r11_q), 32'(a1_q), 11), 10, 11);
        t2_a4 = mmul(msub(t1_a4, 32'(a2_q), 11), 2, 11);
        a4_d  = 4'(mmul(msub(t2_a4, 32'(a3_q), 11), 6, 11));
        sum_w = 32'(a1_q) + 32 * 32'(a2_q) + 544 * 32'(a3_q) + 7072 * 32'(a4_q);
        x_d   = X_W'(sum_w);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            r17_q       <= '0;
            r13_q       <= '0;
            r11_q       <= '0;
            a1_q        <= '0;
            a2_q        <= '0;
            a3_q        <= '0;
            a4_q        <= '0;
            err_flag_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_x_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        r17_q      <= r17;
                        r13_q      <= r13;
                        r11_q      <= r11;
                        a1_q       <= r32;
                        err_flag_q <= (CHECK_RANGE != 0) &&
                                      ((r17 > 5'd16) || (r13 > 4'd12) || (r11 > 4'd10));
                        state_q    <= StA2;
                    end
                end
                StA2: begin
                    a2_q    <= a2_d;
                    state_q <= StA3;
                end
                StA3: begin
                    a3_q    <= a3_d;
                    state_q <= StA4;
                end
                StA4: begin
                    a4_q    <= a4_d;
                    state_q <= StSum;
                end
                StSum: begin
                    out_x_q     <= err_flag_q ? '0 : x_d;
                    err_q       <= err_flag_q;
                    out_valid_q <= 1'b1;
                    state_q     <= StOut;
                end
                StOut: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Gated by reset so in_ready is low during reset and high as soon as it is released.
    assign in_ready  = rst_n && (state_q == StIdle);
    assign out_valid = out_valid_q;
    assign out_x     = out_x_q;
    assign err       = err_q;

endmodule
